// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, data width and the
// baud-divider counter width helper (also meant for uart_tx).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // Width of a counter that spans one full bit period of 2*clk_div cycles.
    function automatic int uart_div_width(input int clk_div);
        return $clog2(2 * clk_div);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output port of uart_rx: valid/ready handshake plus error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rvalid;
    logic                      rready;
    logic [UART_DATA_BITS-1:0] rdata;
    logic                      frame_err;
    logic                      overflow;

    modport master (
        output rvalid,
        output rdata,
        output frame_err,
        output overflow,
        input  rready
    );

    modport slave (
        input  rvalid,
        input  rdata,
        input  frame_err,
        input  overflow,
        output rready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO of 2^FIFO_ASIZE entries for uart_rx.
// Only instantiated when UART_RX_FIFO_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_ASIZE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      empty,
    output logic                      full
);
    localparam int DEPTH = 1 << FIFO_ASIZE;
    localparam logic [FIFO_ASIZE:0]   DEPTH_C = {1'b1, {FIFO_ASIZE{1'b0}}};
    localparam logic [FIFO_ASIZE:0]   CNT_ONE = (FIFO_ASIZE + 1)'(1);
    localparam logic [FIFO_ASIZE-1:0] PTR_ONE = FIFO_ASIZE'(1);

    logic [UART_DATA_BITS-1:0] mem_r [DEPTH];
    logic [FIFO_ASIZE-1:0]     wr_ptr_r;
    logic [FIFO_ASIZE-1:0]     rd_ptr_r;
    logic [FIFO_ASIZE:0]       count_r;
    logic                      wr_en_s;
    logic                      rd_en_s;

    assign full    = (count_r == DEPTH_C);
    assign empty   = (count_r == '0);
    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign wr_en_s = push & (~full | pop);
    assign rd_en_s = pop & ~empty;
    assign dout    = mem_r[rd_ptr_r];

    // Storage array, kept reset-free so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output.
// Define UART_RX_FIFO_EN for a 2^FIFO_ASIZE-entry FIFO; otherwise a
// single holding register buffers the received byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_CLK_DIV = 434,
    parameter int FIFO_ASIZE   = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_uart_rx,
    uart_rx_if.master rx
);
    localparam int               CNT_W     = uart_div_width(UART_CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(2 * UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      sync1_r;
    logic                      rxs_r;
    uart_rx_state_t            state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [2:0]                bit_idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] push_data_r;
    logic                      push_r;
    logic                      frame_err_r;
    logic                      overflow_r;
    logic                      buf_valid_s;
    logic                      buf_full_s;
    logic [UART_DATA_BITS-1:0] buf_data_s;
    logic                      pop_s;

    // Two-flop synchronizer; resetting to the idle-high level avoids a false start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= i_uart_rx;
            rxs_r   <= sync1_r;
        end
    end

    // Bit-level FSM: mid-bit sampling, LSB-first shift, stop check and push request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_BREAK;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= '0;
            push_data_r <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_BREAK: begin
                    // Wait for the line to go idle so a held-low line is never decoded.
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!rxs_r) begin
                        cnt_r   <= HALF_LOAD;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_r == '0) begin
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r     <= BIT_LOAD;
                            bit_idx_r <= 3'd0;
                            state_r   <= ST_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == '0) begin
                        shift_r <= {rxs_r, shift_r[UART_DATA_BITS-1:1]};
                        cnt_r   <= BIT_LOAD;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == '0) begin
                        if (rxs_r) begin
                            push_r      <= 1'b1;
                            push_data_r <= shift_r;
                            state_r     <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_BREAK;
                end
            endcase
        end
    end

    assign pop_s = buf_valid_s & rx.rready;

`ifdef UART_RX_FIFO_EN
    logic buf_empty_s;

    uart_rx_fifo #(
        .FIFO_ASIZE (FIFO_ASIZE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .din   (push_data_r),
        .pop   (pop_s),
        .dout  (buf_data_s),
        .empty (buf_empty_s),
        .full  (buf_full_s)
    );

    assign buf_valid_s = ~buf_empty_s;
`else
    logic                      hold_valid_r;
    logic [UART_DATA_BITS-1:0] hold_data_r;

    // Single-entry buffer; a push lands when empty or when the current byte pops on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= '0;
        end else if (push_r && (!hold_valid_r || pop_s)) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= push_data_r;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    assign buf_valid_s = hold_valid_r;
    assign buf_full_s  = hold_valid_r;
    assign buf_data_s  = hold_data_r;
`endif

    // Flag a good byte dropped because the buffer was full with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= push_r & buf_full_s & ~pop_s;
        end
    end

    assign rx.rvalid    = buf_valid_s;
    assign rx.rdata     = buf_valid_s ? buf_data_s : '0;
    assign rx.frame_err = frame_err_r;
    assign rx.overflow  = overflow_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with UART_CLK_DIV=4 (T=8 cycles).
module tb_uart_rx;
    localparam int DIV   = 4;
    localparam int T     = 2 * DIV;
    localparam int ASIZE = 2;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 1 << ASIZE;
`else
    localparam int DEPTH = 1;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;
    logic rdy  = 1'b0;

    uart_rx_if rx_if ();

    uart_rx #(
        .UART_CLK_DIV (DIV),
        .FIFO_ASIZE   (ASIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_uart_rx (line),
        .rx        (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: expected delivered byte stream and buffer occupancy while stalled.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int occ      = 0;
    int exp_ov   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    int hi_cnt   = 0;
    int rise_cyc = -1;

    // Monitor: collect popped bytes, error pulses and check rdata stability under stall.
    initial begin
        logic       prev_stall;
        logic       prev_valid;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall && rx_if.rvalid) begin
                    checks++;
                    if (rx_if.rdata !== prev_data) begin
                        errors++;
                        $display("FAIL rdata_hold: got %h required %h", rx_if.rdata, prev_data);
                    end
                end
                if (rx_if.rvalid && !prev_valid) rise_cyc = cyc;
                if (rx_if.rvalid) hi_cnt++;
                if (rx_if.rvalid && rx_if.rready) got_q.push_back(rx_if.rdata);
                if (rx_if.frame_err) fe_cnt++;
                if (rx_if.overflow) ov_cnt++;
                if (rx_if.frame_err && rx_if.overflow) both_cnt++;
                prev_stall = rx_if.rvalid && !rx_if.rready;
                prev_valid = rx_if.rvalid;
                prev_data  = rx_if.rdata;
            end
        end
    end

    task automatic set_ready(input logic v);
        rdy = v;
        rx_if.rready = v;
        if (v) occ = 0;
    endtask

    // A correctly framed byte: delivered if the consumer is ready or there is room, else dropped.
    task automatic model_good(input logic [7:0] b);
        if (rdy) begin
            exp_q.push_back(b);
        end else if (occ < DEPTH) begin
            exp_q.push_back(b);
            occ++;
        end else begin
            exp_ov++;
        end
    endtask

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_line(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val);
        hold_line(1'b0, T);
        for (int i = 0; i < 8; i++) hold_line(b[i], T);
        hold_line(stop_val, stop_len);
        line = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_ready(1'b0);
        line = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (rx_if.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b required 0", rx_if.rvalid); end
        if (rx_if.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h required 00", rx_if.rdata); end
        if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", rx_if.frame_err); end
        if (rx_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", rx_if.overflow); end
        sync_edge();
        rst = 1'b0;
        hold_line(1'b1, 4);
    endtask

    task automatic test_latency();
        int t0;
        set_ready(1'b1);
        sync_edge();
        hi_cnt   = 0;
        rise_cyc = -1;
        t0 = cyc;
        model_good(8'h55);
        send_frame(8'h55, T, 1'b1);
        hold_line(1'b1, 2 * T);
        checks += 4;
        if (rise_cyc - t0 != 80) begin errors++; $display("FAIL latency: got %0d cycles required 80", rise_cyc - t0); end
        if (hi_cnt != 1) begin errors++; $display("FAIL rvalid_width: got %0d cycles required 1", hi_cnt); end
        if (got_q.size() != 1) begin errors++; $display("FAIL latency_count: got %0d bytes required 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL latency_data: got %h required %h", got_q[0], exp_q[0]); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int fe0, ov0;
        bytes[0] = 8'hA3; bytes[1] = 8'h00; bytes[2] = 8'hFF;
        fe0 = fe_cnt; ov0 = ov_cnt; exp_ov = 0;
        set_ready(1'b0);
        for (int i = 0; i < 3; i++) begin
            model_good(bytes[i]);
            send_frame(bytes[i], DIV + 1, 1'b1);
        end
        hold_line(1'b1, 2 * T);
        set_ready(1'b1);
        hold_line(1'b1, 2 * T);
        checks += 3;
        if (fe_cnt - fe0 != 0) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses required 0", fe_cnt - fe0); end
        if (ov_cnt - ov0 != exp_ov) begin errors++; $display("FAIL b2b_overflow: got %0d pulses required %0d", ov_cnt - ov0, exp_ov); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        set_ready(1'b1);
        hold_line(1'b0, 2);
        hold_line(1'b1, 3 * T);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL glitch_nobyte: got %0d bytes required 0", got_q.size()); end
        model_good(8'h3C);
        send_frame(8'h3C, T, 1'b1);
        hold_line(1'b1, 2 * T);
        checks += 3;
        if (fe_cnt - fe0 != 0) begin errors++; $display("FAIL glitch_frame_err: got %0d required 0", fe_cnt - fe0); end
        if (got_q.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d bytes required 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL glitch_data: got %h required %h", got_q[0], exp_q[0]); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_cnt;
        set_ready(1'b1);
        send_frame(8'h81, 40, 1'b0);
        hold_line(1'b1, 2 * T);
        model_good(8'h12);
        send_frame(8'h12, T, 1'b1);
        hold_line(1'b1, 2 * T);
        checks += 4;
        if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d required 1", fe_cnt - fe0); end
        if (both_cnt != 0) begin errors++; $display("FAIL ferr_coincide: got %0d required 0", both_cnt); end
        if (got_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d bytes required 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL ferr_data: got %h required %h", got_q[0], exp_q[0]); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int ov0;
        ov0 = ov_cnt; exp_ov = 0;
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            model_good(b);
            send_frame(b, T, 1'b1);
        end
        hold_line(1'b1, 2 * T);
        checks += 2;
        if (ov_cnt - ov0 != exp_ov) begin errors++; $display("FAIL ovf_pulses: got %0d required %0d", ov_cnt - ov0, exp_ov); end
        if (rx_if.rvalid !== 1'b1) begin errors++; $display("FAIL ovf_rvalid: got %b required 1", rx_if.rvalid); end
        set_ready(1'b1);
        hold_line(1'b1, 2 * DEPTH + 8);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] p;
        int fe0, ov0;
        set_ready(1'b0);
        model_good(8'h99);
        send_frame(8'h99, T, 1'b1);
        hold_line(1'b1, T);
        p = 8'($urandom_range(0, 255));
        hold_line(1'b0, T);
        for (int i = 0; i < 3; i++) hold_line(p[i], T);
        hold_line(p[3], 3);
        fe0 = fe_cnt; ov0 = ov_cnt;
        rst = 1'b1;
        hold_line(p[3], 3);
        @(negedge clk);
        checks += 3;
        if (rx_if.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b required 0", rx_if.rvalid); end
        if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b required 0", rx_if.frame_err); end
        if (rx_if.overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b required 0", rx_if.overflow); end
        sync_edge();
        exp_q.delete();
        got_q.delete();
        occ = 0;
        line = 1'b1;
        rst = 1'b0;
        hold_line(1'b1, 2 * T);
        set_ready(1'b1);
        model_good(8'h7E);
        send_frame(8'h7E, T, 1'b1);
        hold_line(1'b1, 2 * T);
        checks += 3;
        if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin errors++; $display("FAIL midrst_pulses: got %0d/%0d required 0/0", fe_cnt - fe0, ov_cnt - ov0); end
        if (got_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d bytes required 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_data: got %h required %h", got_q[0], exp_q[0]); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] b;
        set_ready(1'b1);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            model_good(b);
            send_frame(b, $urandom_range(DIV + 1, T), 1'b1);
            hold_line(1'b1, $urandom_range(0, 2 * T));
        end
        hold_line(1'b1, 2 * T);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rx_if.rready = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
